// File: rtl/autosa_csb_pkg.sv
// Shared types and constants for the autosa APB-to-CSB bridge.
package autosa_csb_pkg;

    // Bridge transaction state.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT_RD = 3'd2,
        WAIT_WR = 3'd3,
        DONE    = 3'd4
    } csb_state_e;

    // Default CSB geometry.
    localparam int CSB_AW_DEF = 16;
    localparam int DW_DEF     = 32;

    // APB byte address -> CSB word address shift.
    localparam int ADDR_SHIFT = 2;

endpackage

// File: rtl/autosa_csb_timeout.sv
// Transaction watchdog for the APB-to-CSB bridge: counts cycles while a
// transaction is outstanding and flags expiry on the LIMIT-th cycle.
module autosa_csb_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count starts at 0 on the first busy cycle, so LIMIT-1 marks the last one.
    assign expired = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/autosa_apb2csb_np.sv
// APB-to-CSB bridge with optional non-posted writes, out-of-range address
// error reporting and (with AUTOSA_APB2CSB_TIMEOUT_EN defined) a watchdog
// that aborts transactions the core never finishes.
module autosa_apb2csb_np
    import autosa_csb_pkg::*;
#(
    parameter int APB_AW         = 32,
    parameter int CSB_AW         = CSB_AW_DEF,
    parameter int DW             = DW_DEF,
    parameter int NPOSTED_WR     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              pclk,
    input  logic              prstn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [DW-1:0]     pwdata,
    output logic [DW-1:0]     prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              csb2autosa_valid,
    input  logic              csb2autosa_ready,
    output logic [CSB_AW-1:0] csb2autosa_addr,
    output logic [DW-1:0]     csb2autosa_wdat,
    output logic              csb2autosa_write,
    output logic              csb2autosa_nposted,
    input  logic              autosa2csb_valid,
    input  logic [DW-1:0]     autosa2csb_data,
    input  logic              autosa2csb_wr_complete,
    output logic              err_unexpected_resp
);

    localparam logic NP_EN = 1'(NPOSTED_WR != 0);

    csb_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [CSB_AW-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              unexp_q, unexp_d;
    logic              valid_q, valid_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DW-1:0]     prdata_q, prdata_d;

    logic              addr_hi_err;
    logic              rd_expected;
    logic              wc_expected;
    logic              to_expired;
    logic              unused_byte_lanes;

    // Byte-lane bits never reach the CSB word address.
    assign unused_byte_lanes = ^paddr[ADDR_SHIFT-1:0];

    // Any address bit above the CSB window marks the access out of range.
    if (APB_AW > CSB_AW + ADDR_SHIFT) begin : g_hi_chk
        assign addr_hi_err = |paddr[APB_AW-1:CSB_AW+ADDR_SHIFT];
    end else begin : g_no_hi
        assign addr_hi_err = 1'b0;
    end

`ifdef AUTOSA_APB2CSB_TIMEOUT_EN
    logic to_clr;
    logic to_en;

    // Holding the counter clear outside a transaction leaves it at 0 on REQ entry.
    assign to_clr = (state_q == IDLE) || (state_q == DONE);
    assign to_en  = (state_q == REQ) || (state_q == WAIT_RD) || (state_q == WAIT_WR);

    autosa_csb_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (pclk),
        .rst_n   (prstn),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign to_expired         = 1'b0;
`endif

    // Next-state, request latching, response capture and registered APB outputs.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        unexp_d     = unexp_q;
        rd_expected = 1'b0;
        wc_expected = 1'b0;

        case (state_q)
            IDLE: begin
                if (psel && penable) begin
                    write_d = pwrite;
                    wdata_d = pwdata;
                    addr_d  = paddr[CSB_AW+ADDR_SHIFT-1:ADDR_SHIFT];
                    err_d   = addr_hi_err;
                    state_d = addr_hi_err ? DONE : REQ;
                end
            end
            REQ: begin
                if (csb2autosa_ready) begin
                    if (!write_q) begin
                        rd_expected = 1'b1;
                        if (autosa2csb_valid) begin
                            rdata_d = autosa2csb_data;
                            state_d = DONE;
                        end else begin
                            state_d = WAIT_RD;
                        end
                    end else if (NP_EN) begin
                        wc_expected = 1'b1;
                        state_d     = autosa2csb_wr_complete ? DONE : WAIT_WR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT_RD: begin
                rd_expected = 1'b1;
                if (autosa2csb_valid) begin
                    rdata_d = autosa2csb_data;
                    state_d = DONE;
                end
            end
            WAIT_WR: begin
                wc_expected = 1'b1;
                if (autosa2csb_wr_complete) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completion arriving on the expiry cycle still wins over the abort.
        if (to_expired && (state_d != DONE)) begin
            state_d = DONE;
            err_d   = 1'b1;
        end

        if ((autosa2csb_valid && !rd_expected) ||
            (autosa2csb_wr_complete && !wc_expected)) begin
            unexp_d = 1'b1;
        end

        valid_d   = (state_d == REQ);
        pready_d  = (state_d == DONE);
        pslverr_d = (state_d == DONE) && err_d;
        prdata_d  = ((state_d == DONE) && !write_d && !err_d) ? rdata_d : '0;
    end

    // State and output registers; reset aborts any access without a response.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            unexp_q   <= 1'b0;
            valid_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            unexp_q   <= unexp_d;
            valid_q   <= valid_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign csb2autosa_valid    = valid_q;
    assign csb2autosa_addr     = addr_q;
    assign csb2autosa_wdat     = wdata_q;
    assign csb2autosa_write    = write_q;
    assign csb2autosa_nposted  = write_q & NP_EN;
    assign pready              = pready_q;
    assign pslverr             = pslverr_q;
    assign prdata              = prdata_q;
    assign err_unexpected_resp = unexp_q;

endmodule

// File: tb/tb_autosa_apb2csb_np.sv
// Directed self-checking bench for autosa_apb2csb_np: a non-posted instance
// carries most scenarios, a posted-write instance covers NPOSTED_WR=0.
`timescale 1ns/1ps
module tb_autosa_apb2csb_np;

    logic        pclk = 1'b0;
    logic        prstn;
    logic        psel, psel_p, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        rdy, rsp_v, wcpl;
    logic [31:0] rsp_d;

    logic [31:0] prdata, prdata_p;
    logic        pready, pready_p, pslverr, pslverr_p;
    logic        v, v_p, wr, wr_p, np, np_p, unexp, unexp_p;
    logic [15:0] a, a_p;
    logic [31:0] wd, wd_p;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 pclk = ~pclk;

    autosa_apb2csb_np #(
        .APB_AW(32), .CSB_AW(16), .DW(32), .NPOSTED_WR(1), .TIMEOUT_CYCLES(8)
    ) u_dut (
        .pclk(pclk), .prstn(prstn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .csb2autosa_valid(v), .csb2autosa_ready(rdy), .csb2autosa_addr(a),
        .csb2autosa_wdat(wd), .csb2autosa_write(wr), .csb2autosa_nposted(np),
        .autosa2csb_valid(rsp_v), .autosa2csb_data(rsp_d),
        .autosa2csb_wr_complete(wcpl), .err_unexpected_resp(unexp)
    );

    autosa_apb2csb_np #(
        .APB_AW(32), .CSB_AW(16), .DW(32), .NPOSTED_WR(0), .TIMEOUT_CYCLES(8)
    ) u_dut_p (
        .pclk(pclk), .prstn(prstn), .psel(psel_p), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_p), .pready(pready_p), .pslverr(pslverr_p),
        .csb2autosa_valid(v_p), .csb2autosa_ready(rdy), .csb2autosa_addr(a_p),
        .csb2autosa_wdat(wd_p), .csb2autosa_write(wr_p), .csb2autosa_nposted(np_p),
        .autosa2csb_valid(rsp_v), .autosa2csb_data(rsp_d),
        .autosa2csb_wr_complete(wcpl), .err_unexpected_resp(unexp_p)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Setup phase, then access phase; returns at the negedge of trigger cycle T.
    task automatic apb_start(input logic to_posted, input logic wr_i,
                             input logic [31:0] ad, input logic [31:0] wdat);
        @(posedge pclk); #1;
        psel    = !to_posted;
        psel_p  = to_posted;
        penable = 1'b0;
        pwrite  = wr_i;
        paddr   = ad;
        pwdata  = wdat;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
    endtask

    task automatic apb_end();
        psel    = 1'b0;
        psel_p  = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prstn = 1'b0; psel = 1'b0; psel_p = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; rdy = 1'b1; rsp_v = 1'b0; rsp_d = 32'hDEAD_BEEF; wcpl = 1'b0;

        // Reset state.
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_pready", pready, 0);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_valid", v, 0);
        chk("rst_addr", a, 0);
        chk("rst_nposted", np, 0);
        chk("rst_unexp", unexp, 0);
        prstn = 1'b1;

        // Posted write: request at T+1, pready at T+2.
        apb_start(1'b1, 1'b1, 32'h0000_1004, 32'hA5A5_0001);
        for (int k = 1; k <= 3; k++) begin
            @(posedge pclk); #1;
            if (k == 3) apb_end();
            @(negedge pclk);
            chk("pw_pready", pready_p, k == 2);
            if (k == 1) begin
                chk("pw_valid", v_p, 1);
                chk("pw_addr", a_p, 16'h0401);
                chk("pw_write", wr_p, 1);
                chk("pw_nposted", np_p, 0);
                chk("pw_wdat", wd_p, 32'hA5A5_0001);
            end
            if (k == 2) begin
                chk("pw_pslverr", pslverr_p, 0);
                chk("pw_valid_off", v_p, 0);
            end
        end

        // Non-posted write: accept at T+1, wr_complete at T+5, pready only at T+6.
        apb_start(1'b0, 1'b1, 32'h0000_0008, 32'h0BAD_CAFE);
        for (int k = 1; k <= 7; k++) begin
            @(posedge pclk); #1;
            wcpl = (k == 5);
            if (k == 7) apb_end();
            @(negedge pclk);
            chk("npw_pready", pready, k == 6);
            if (k == 1) begin
                chk("npw_valid", v, 1);
                chk("npw_nposted", np, 1);
                chk("npw_addr", a, 16'h0002);
                chk("npw_write", wr, 1);
            end
            if (k == 3) chk("npw_valid_off", v, 0);
            if (k == 6) chk("npw_pslverr", pslverr, 0);
        end

        // Read with ready stalled 3 cycles, data two cycles after accept.
        rdy = 1'b0;
        apb_start(1'b0, 1'b0, 32'h0000_0010, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge pclk); #1;
            rdy   = (k == 4);
            rsp_v = (k == 6);
            rsp_d = (k == 6) ? 32'h1234_5678 : 32'hDEAD_BEEF;
            if (k == 8) apb_end();
            @(negedge pclk);
            chk("rd_pready", pready, k == 7);
            chk("rd_prdata", prdata, (k == 7) ? 32'h1234_5678 : 32'h0);
            if (k <= 4) begin
                chk("rd_valid_stall", v, 1);
                chk("rd_addr_stall", a, 16'h0004);
                chk("rd_write_stall", wr, 0);
                chk("rd_nposted", np, 0);
            end
            if (k == 5) chk("rd_valid_off", v, 0);
        end
        rdy = 1'b1; rsp_v = 1'b0;

        // Out-of-range address: no CSB request, error response at T+1.
        apb_start(1'b0, 1'b0, 32'h0004_0000, 32'h0);
        chk("oor_valid_T", v, 0);
        for (int k = 1; k <= 2; k++) begin
            @(posedge pclk); #1;
            if (k == 2) apb_end();
            @(negedge pclk);
            chk("oor_pready", pready, k == 1);
            chk("oor_pslverr", pslverr, k == 1);
            chk("oor_prdata", prdata, 0);
            chk("oor_valid", v, 0);
        end

        // Read accepted and answered in the same cycle; byte-lane bits ignored.
        apb_start(1'b0, 1'b0, 32'h0000_0023, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge pclk); #1;
            rsp_v = (k == 1);
            rsp_d = (k == 1) ? 32'hCAFE_F00D : 32'hDEAD_BEEF;
            if (k == 3) apb_end();
            @(negedge pclk);
            chk("sc_pready", pready, k == 2);
            chk("sc_prdata", prdata, (k == 2) ? 32'hCAFE_F00D : 32'h0);
            if (k == 1) chk("sc_addr", a, 16'h0008);
        end
        rsp_v = 1'b0;
        chk("no_unexp_yet", unexp, 0);

`ifdef AUTOSA_APB2CSB_TIMEOUT_EN
        // Unanswered read aborts after 8 busy cycles; a late response is flagged.
        apb_start(1'b0, 1'b0, 32'h0000_0030, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge pclk); #1;
            if (k == 10) apb_end();
            @(negedge pclk);
            chk("to_pready", pready, k == 9);
            chk("to_pslverr", pslverr, k == 9);
            chk("to_prdata", prdata, 0);
        end
        @(posedge pclk); #1; rsp_v = 1'b1; rsp_d = 32'h0000_1111;
        @(posedge pclk); #1; rsp_v = 1'b0;
        @(negedge pclk);
        chk("to_late_unexp", unexp, 1);
`endif

        // Spurious response in IDLE sets the sticky flag.
        @(posedge pclk); #1; rsp_v = 1'b1; rsp_d = 32'h0000_2222;
        @(posedge pclk); #1; rsp_v = 1'b0;
        @(negedge pclk);
        chk("sp_unexp", unexp, 1);
        chk("sp_pready", pready, 0);
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("sp_unexp_sticky", unexp, 1);

        // The next legal read still completes normally.
        apb_start(1'b0, 1'b0, 32'h0000_0044, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge pclk); #1;
            rsp_v = (k == 2);
            rsp_d = (k == 2) ? 32'h5A5A_1234 : 32'hDEAD_BEEF;
            if (k == 4) apb_end();
            @(negedge pclk);
            chk("lr_pready", pready, k == 3);
            chk("lr_prdata", prdata, (k == 3) ? 32'h5A5A_1234 : 32'h0);
            if (k == 1) chk("lr_addr", a, 16'h0011);
            if (k == 3) chk("lr_pslverr", pslverr, 0);
        end
        rsp_v = 1'b0;
        chk("lr_unexp_sticky", unexp, 1);

        // Reset during a stalled request drops valid at once, no response follows.
        rdy = 1'b0;
        apb_start(1'b0, 1'b0, 32'h0000_0050, 32'h0);
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("ar_valid_before", v, 1);
        #2 prstn = 1'b0;
        #1;
        chk("ar_valid_async", v, 0);
        chk("ar_pready_async", pready, 0);
        chk("ar_unexp_cleared", unexp, 0);
        apb_end();
        @(negedge pclk);
        prstn = 1'b1;
        rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge pclk);
            chk("ar_no_pready", pready, 0);
            chk("ar_no_valid", v, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
